load_store_unit: RTL and testbench

- Parametrised memory stage for the MIPS150 pipeline.
- Accepts one load/store request per transaction and splits it by address. Data memory handles the RAM region. The UART valid/ready pins handle the memory-mapped I/O region.
- Produces big-endian byte/half/word alignment, sign or zero extension, and byte-lane write enables.
- Provides configurable RAM read latency and blocking or non-blocking UART access. While a transaction is in flight, it holds the pipeline through `stall`.

---
 rtl/load_store_unit_pkg.sv | 73 +++++++
 rtl/load_store_unit_load_align.sv | 14 +
 rtl/load_store_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, I/O register offsets,
// FSM states and the big-endian lane helpers used by the unit and writeback.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] IO_TX_READY = 4'h0;
    localparam logic [3:0] IO_RX_VALID = 4'h4;
    localparam logic [3:0] IO_RX_DATA  = 4'h8;
    localparam logic [3:0] IO_TX_DATA  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_RD,
        ST_IO_WAIT,
        ST_RESP
    } lsu_state_e;

    // Size code 2'b11 behaves as a word everywhere.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lsu_store_we(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] we;
        case (size)
            SZ_BYTE: we = 4'b1000 >> off;
            SZ_HALF: we = off[1] ? 4'b0011 : 4'b1100;
            default: we = 4'b1111;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Offset 0 is the most significant byte of the word.
    function automatic logic [31:0] lsu_align_load(input logic [31:0] data, input logic [1:0] off,
                                                   input logic [1:0] size, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = data[31:24];
            2'd1:    b = data[23:16];
            2'd2:    b = data[15:8];
            default: b = data[7:0];
        endcase
        h = off[1] ? data[15:0] : data[31:16];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational extract/extend of a loaded word; also usable by the writeback stage.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    assign result = lsu_align_load(data, off, size, is_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// MIPS150 memory stage: routes each load/store to data RAM or the UART I/O
// window, handles alignment/extension and holds the pipeline while busy.
//
// state      | meaning
// IDLE       | accepting a request; RAM/UART strobes driven combinationally
// MEM_RD     | waiting out RAM read latency (down-counter)
// IO_WAIT    | blocking UART access waiting for its handshake
// RESP       | one-cycle turnaround before the registered response
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DMEM_AW     = 12,
    parameter int unsigned RD_LATENCY  = 1,
    parameter logic [3:0]  IO_NIBBLE   = 4'h8,
    parameter bit          BLOCKING_IO = 1'b1
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_store,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               stall,
    output logic               resp_valid,
    output logic [31:0]        resp_data,
    output logic               misaligned,
    output logic               mem_en,
    output logic [3:0]         mem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic [7:0]         DataIn,
    output logic               DataInValid,
    input  logic               DataInReady,
    input  logic [7:0]         DataOut,
    input  logic               DataOutValid,
    output logic               DataOutReady
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        store_q, store_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        misaligned_q, misaligned_d;

    logic        mis_cond;
    logic        is_io;
    logic [31:0] ram_load_data;
    logic        addr_unused;

    assign mis_cond    = lsu_misaligned(req_size, req_addr[1:0]);
    assign is_io       = (req_addr[31:28] == IO_NIBBLE);
    assign addr_unused = ^req_addr;

    load_align u_align (
        .data        (mem_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ram_load_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        store_d      = store_q;
        tx_byte_d    = tx_byte_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'h0;
        misaligned_d = 1'b0;
        stall        = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 4'h0;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        DataIn       = 8'h0;
        DataInValid  = 1'b0;
        DataOutReady = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && mis_cond) begin
                    misaligned_d = 1'b1;
                    resp_valid_d = 1'b1;
                end else if (req_valid) begin
                    stall     = 1'b1;
                    off_d     = req_addr[1:0];
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    store_d   = req_store;
                    tx_byte_d = req_wdata[7:0];
                    rdata_d   = 32'h0;
                    if (!is_io) begin
                        mem_en   = 1'b1;
                        mem_addr = req_addr[DMEM_AW+1:2];
                        if (req_store) begin
                            mem_we    = lsu_store_we(req_size, req_addr[1:0]);
                            mem_wdata = lsu_store_data(req_size, req_wdata);
                            state_d   = ST_RESP;
                        end else begin
                            cnt_d   = 2'(RD_LATENCY - 1);
                            state_d = ST_MEM_RD;
                        end
                    end else begin
                        // Handshakes complete here when the UART is already ready.
                        state_d = ST_RESP;
                        case (req_addr[3:0])
                            IO_TX_READY: if (!req_store) rdata_d = {31'b0, DataInReady};
                            IO_RX_VALID: if (!req_store) rdata_d = {31'b0, DataOutValid};
                            IO_RX_DATA: begin
                                if (!req_store) begin
                                    if (DataOutValid) begin
                                        DataOutReady = 1'b1;
                                        rdata_d      = {24'b0, DataOut};
                                    end else if (BLOCKING_IO) begin
                                        state_d = ST_IO_WAIT;
                                    end
                                end
                            end
                            IO_TX_DATA: begin
                                if (req_store) begin
                                    DataInValid = 1'b1;
                                    DataIn      = req_wdata[7:0];
                                    if (!DataInReady && BLOCKING_IO) state_d = ST_IO_WAIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_MEM_RD: begin
                stall = 1'b1;
                if (cnt_q == 2'd0) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = ram_load_data;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_IO_WAIT: begin
                stall = 1'b1;
                if (store_q) begin
                    DataInValid = 1'b1;
                    DataIn      = tx_byte_q;
                    if (DataInReady) begin
                        resp_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end else if (DataOutValid) begin
                    DataOutReady = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_data_d  = {24'b0, DataOut};
                    state_d      = ST_IDLE;
                end
            end
            ST_RESP: begin
                stall        = 1'b1;
                resp_valid_d = 1'b1;
                resp_data_d  = rdata_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes must drop the moment reset is applied, not at the next edge.
        if (reset) begin
            stall        = 1'b0;
            mem_en       = 1'b0;
            mem_we       = 4'h0;
            mem_addr     = '0;
            mem_wdata    = 32'h0;
            DataIn       = 8'h0;
            DataInValid  = 1'b0;
            DataOutReady = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            store_q      <= 1'b0;
            tx_byte_q    <= 8'h0;
            rdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            store_q      <= store_d;
            tx_byte_q    <= tx_byte_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed RAM/UART/reset scenarios plus random RAM
// traffic checked against a byte-array memory model.
module tb_load_store_unit;

    localparam int RD_LAT = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic        ram_clr;
    logic        req_valid_b, req_valid_nb, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        DataInReady, DataOutValid;
    logic [7:0]  DataOut;

    logic        b_stall, b_resp_valid, b_misaligned, b_mem_en, b_DataInValid, b_DataOutReady;
    logic [31:0] b_resp_data, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_we;
    logic [11:0] b_mem_addr;
    logic [7:0]  b_DataIn;

    logic        nb_stall, nb_resp_valid, nb_misaligned, nb_mem_en, nb_DataInValid, nb_DataOutReady;
    logic [31:0] nb_resp_data, nb_mem_wdata;
    logic [3:0]  nb_mem_we;
    logic [11:0] nb_mem_addr;
    logic [7:0]  nb_DataIn;

    logic        sel_nb;
    logic        o_stall, o_resp_valid, o_misaligned, o_mem_en, o_DataInValid, o_DataOutReady;
    logic [31:0] o_resp_data, o_mem_wdata;
    logic [3:0]  o_mem_we;
    logic [7:0]  o_DataIn;
    logic [95:0] b_vec, nb_vec;

    always #5 CLK = ~CLK;

    load_store_unit #(.DMEM_AW(12), .RD_LATENCY(RD_LAT), .IO_NIBBLE(4'h8), .BLOCKING_IO(1'b1)) u_blk (
        .CLK(CLK), .reset(reset), .req_valid(req_valid_b), .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(b_stall),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data), .misaligned(b_misaligned), .mem_en(b_mem_en),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .DataIn(b_DataIn), .DataInValid(b_DataInValid), .DataInReady(DataInReady), .DataOut(DataOut),
        .DataOutValid(DataOutValid), .DataOutReady(b_DataOutReady));

    load_store_unit #(.DMEM_AW(12), .RD_LATENCY(RD_LAT), .IO_NIBBLE(4'h8), .BLOCKING_IO(1'b0)) u_nb (
        .CLK(CLK), .reset(reset), .req_valid(req_valid_nb), .req_store(req_store), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(nb_stall),
        .resp_valid(nb_resp_valid), .resp_data(nb_resp_data), .misaligned(nb_misaligned), .mem_en(nb_mem_en),
        .mem_we(nb_mem_we), .mem_addr(nb_mem_addr), .mem_wdata(nb_mem_wdata), .mem_rdata(32'h0),
        .DataIn(nb_DataIn), .DataInValid(nb_DataInValid), .DataInReady(DataInReady), .DataOut(DataOut),
        .DataOutValid(DataOutValid), .DataOutReady(nb_DataOutReady));

    always_comb begin
        o_stall        = sel_nb ? nb_stall        : b_stall;
        o_resp_valid   = sel_nb ? nb_resp_valid   : b_resp_valid;
        o_resp_data    = sel_nb ? nb_resp_data    : b_resp_data;
        o_misaligned   = sel_nb ? nb_misaligned   : b_misaligned;
        o_mem_en       = sel_nb ? nb_mem_en       : b_mem_en;
        o_mem_we       = sel_nb ? nb_mem_we       : b_mem_we;
        o_mem_wdata    = sel_nb ? nb_mem_wdata    : b_mem_wdata;
        o_DataIn       = sel_nb ? nb_DataIn       : b_DataIn;
        o_DataInValid  = sel_nb ? nb_DataInValid  : b_DataInValid;
        o_DataOutReady = sel_nb ? nb_DataOutReady : b_DataOutReady;
        b_vec  = {2'b0, b_stall, b_resp_valid, b_misaligned, b_mem_en, b_resp_data, b_mem_we, b_mem_addr,
                  b_mem_wdata, b_DataIn, b_DataInValid, b_DataOutReady};
        nb_vec = {2'b0, nb_stall, nb_resp_valid, nb_misaligned, nb_mem_en, nb_resp_data, nb_mem_we, nb_mem_addr,
                  nb_mem_wdata, nb_DataIn, nb_DataInValid, nb_DataOutReady};
    end

    // Data RAM attached to the blocking instance: lane writes, RD_LAT-stage read pipe.
    logic [31:0] ram [0:255];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    always @(posedge CLK) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (b_mem_en) begin
            for (int l = 0; l < 4; l++)
                if (b_mem_we[l]) ram[b_mem_addr[7:0]][8*l +: 8] <= b_mem_wdata[8*l +: 8];
            rd_pipe[0] <= ram[b_mem_addr[7:0]];
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign b_mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model: byte-addressed memory, byte 0 is the most significant of a word.
    logic [7:0] ref_mem [0:1023];

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic uns);
        int val;
        if (sz == 2'd0) begin
            val = int'(ref_mem[a]);
            if (!uns && val >= 128) val = val - 256;
        end else if (sz == 2'd1) begin
            val = int'(ref_mem[a]) * 256 + int'(ref_mem[a+1]);
            if (!uns && val >= 32768) val = val - 65536;
        end else begin
            return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
        end
        return 32'(val);
    endfunction

    task automatic ref_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[a+i] = 8'((wd >> (8*(n-1-i))) & 32'hFF);
    endtask

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] r_data, r_wd0;
    logic [3:0]  r_we0;
    logic [7:0]  r_din0, r_din_hs;
    logic        r_mis;
    int          r_lat, r_en, r_div, r_dor, r_stall_err;

    // Presents one request right after a rising edge and watches it to completion.
    task automatic do_req(input logic nb, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int rdy_at, input int vld_at);
        sel_nb = nb; req_store = st; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        if (nb) req_valid_nb = 1'b1; else req_valid_b = 1'b1;
        DataInReady = (rdy_at <= 0); DataOutValid = (vld_at <= 0);
        r_lat = -1; r_data = 32'h0; r_mis = 1'b0; r_en = 0; r_div = 0; r_dor = 0; r_stall_err = 0;
        r_we0 = 4'h0; r_wd0 = 32'h0; r_din0 = 8'h0; r_din_hs = 8'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (c == 0) begin r_we0 = o_mem_we; r_wd0 = o_mem_wdata; r_din0 = o_DataIn; end
            if (o_mem_en) r_en++;
            if (o_DataInValid) r_div++;
            if (o_DataInValid && DataInReady) r_din_hs = o_DataIn;
            if (o_DataOutReady) r_dor++;
            if (o_resp_valid) begin
                r_lat = c; r_data = o_resp_data; r_mis = o_misaligned;
                if (o_stall) r_stall_err++;
            end else if (!o_stall) begin
                r_stall_err++;
            end
            @(posedge CLK); #1;
            req_valid_b = 1'b0; req_valid_nb = 1'b0;
            DataInReady = (c + 1 >= rdy_at); DataOutValid = (c + 1 >= vld_at);
            if (r_lat >= 0) break;
        end
        DataInReady = 1'b0; DataOutValid = 1'b0;
    endtask

    task automatic expect_txn(input string tag, input logic [31:0] edata, input int elat,
                              input logic emis, input int een);
        check({tag, ".data"}, r_data, edata);
        check({tag, ".lat"}, r_lat, elat);
        check({tag, ".mis"}, r_mis, emis);
        check({tag, ".mem_en"}, r_en, een);
        check({tag, ".stall"}, r_stall_err, emis ? 1 : 0);
    endtask

    initial begin
        int n;
        logic st, un, emis;
        logic [1:0] sz;
        logic [31:0] wd, ed;
        int a;

        reset = 1'b1; ram_clr = 1'b1; sel_nb = 1'b0;
        req_valid_b = 1'b0; req_valid_nb = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        DataInReady = 1'b0; DataOutValid = 1'b0; DataOut = 8'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outs_blk", b_vec, 96'h0);
        check("reset_outs_nb", nb_vec, 96'h0);
        @(posedge CLK); #1;
        reset = 1'b0; ram_clr = 1'b0;

        // RAM word store, signed byte load, byte store lanes, LHU, misaligned word
        do_req(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 1000);
        expect_txn("sw_100", 32'h0, 2, 0, 1);
        check("sw_100.we", r_we0, 4'b1111);
        ref_store(32'h100, 2'd2, 32'hDEADBEEF);

        do_req(0, 0, 2'd0, 0, 32'h101, 32'h0, 0, 1000);
        expect_txn("lb_101", 32'hFFFFFFAD, 3, 0, 1);
        check("lb_101.model", r_data, ref_load(32'h101, 2'd0, 1'b0));

        do_req(0, 1, 2'd0, 0, 32'h102, 32'h0000005A, 0, 1000);
        expect_txn("sb_102", 32'h0, 2, 0, 1);
        check("sb_102.we", r_we0, 4'b0010);
        check("sb_102.wdata", r_wd0, 32'h5A5A5A5A);
        ref_store(32'h102, 2'd0, 32'h5A);

        do_req(0, 0, 2'd1, 1, 32'h102, 32'h0, 0, 1000);
        expect_txn("lhu_102", 32'h00005AEF, 3, 0, 1);

        do_req(0, 0, 2'd2, 0, 32'h102, 32'h0, 0, 1000);
        expect_txn("lw_mis", 32'h0, 1, 1, 0);

        // Blocking UART transmit with the transmitter busy for five cycles
        do_req(0, 1, 2'd0, 0, 32'h8000000C, 32'h123456A5, 5, 1000);
        expect_txn("tx_blk", 32'h0, 6, 0, 0);
        check("tx_blk.div_cycles", r_div, 6);
        check("tx_blk.din0", r_din0, 8'hA5);
        check("tx_blk.din_hs", r_din_hs, 8'hA5);

        DataOut = 8'h41;
        do_req(0, 0, 2'd2, 0, 32'h80000008, 32'h0, 1000, 3);
        expect_txn("rx_blk", 32'h41, 4, 0, 0);
        check("rx_blk.dor", r_dor, 1);

        do_req(0, 0, 2'd2, 0, 32'h80000000, 32'h0, 0, 1000);
        expect_txn("stat_txrdy", 32'h1, 2, 0, 0);
        do_req(0, 0, 2'd2, 0, 32'h80000004, 32'h0, 1000, 0);
        expect_txn("stat_rxvld", 32'h1, 2, 0, 0);
        check("stat_rxvld.dor", r_dor, 0);
        do_req(0, 0, 2'd0, 0, 32'h80000001, 32'h0, 0, 0);
        expect_txn("io_other", 32'h0, 2, 0, 0);

        // Non-blocking instance
        DataOut = 8'h41;
        do_req(1, 0, 2'd2, 0, 32'h80000008, 32'h0, 1000, 1000);
        expect_txn("rx_nb_empty", 32'h0, 2, 0, 0);
        check("rx_nb_empty.dor", r_dor, 0);
        do_req(1, 0, 2'd2, 0, 32'h80000008, 32'h0, 1000, 0);
        expect_txn("rx_nb_full", 32'h41, 2, 0, 0);
        check("rx_nb_full.dor", r_dor, 1);
        do_req(1, 1, 2'd0, 0, 32'h8000000C, 32'h33, 1000, 1000);
        expect_txn("tx_nb_drop", 32'h0, 2, 0, 0);
        check("tx_nb_drop.div", r_div, 1);
        sel_nb = 1'b0;

        // Reset while a RAM read is in flight
        req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100; req_valid_b = 1'b1;
        @(posedge CLK); #1;
        req_valid_b = 1'b0;
        @(negedge CLK);
        check("midrd.stall_before", b_stall, 1);
        reset = 1'b1; #1;
        check("midrd.outs", b_vec, 96'h0);
        n = 0;
        repeat (2) begin @(negedge CLK); if (b_resp_valid) n++; @(posedge CLK); #1; end
        reset = 1'b0;
        repeat (4) begin @(negedge CLK); if (b_resp_valid) n++; @(posedge CLK); #1; end
        check("midrd.no_resp", n, 0);
        do_req(0, 0, 2'd2, 0, 32'h100, 32'h0, 0, 1000);
        expect_txn("after_rst_lw", ref_load(32'h100, 2'd2, 1'b0), 3, 0, 1);

        // Reset while waiting on the UART transmitter
        req_store = 1'b1; req_size = 2'd0; req_addr = 32'h8000000C; req_wdata = 32'h77;
        DataInReady = 1'b0; req_valid_b = 1'b1;
        @(posedge CLK); #1;
        req_valid_b = 1'b0;
        @(negedge CLK);
        check("iowait.div_before", b_DataInValid, 1);
        reset = 1'b1; #1;
        check("iowait.div_after", b_DataInValid, 0);
        check("iowait.stall_after", b_stall, 0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(posedge CLK); #1;

        // Random RAM traffic against the byte model
        for (int t = 0; t < 60; t++) begin
            st = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 1023));
            wd = $urandom;
            emis = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
            ed = (emis || st) ? 32'h0 : ref_load(a, sz, un);
            do_req(0, st, sz, un, 32'(a), wd, 0, 1000);
            expect_txn($sformatf("rnd%0d", t), ed, emis ? 1 : (st ? 2 : RD_LAT + 1), emis, emis ? 0 : 1);
            if (st && !emis) ref_store(a, sz, wd);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
